apb_rr_scheduler: RTL and testbench
===================================

Name: apb_rr_scheduler

Overview:
Round-robin scheduler that shares the single APB bus (3-bit address, 5-bit data) between NREQ independent requesters. It accepts one command at a time from the winning requester and sequences the APB SETUP and ACCESS phases itself. It returns read data, completion and a timeout error to the winning requester. It sits between the requester logic and the APB slave, in place of a dedicated per-client master.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 3, APB address width
DW, 5, APB data width
TIMEOUT, 15, ACCESS cycles without pready before abort; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester command request; level, held until gnt
req_wr  in  NREQ  per-requester direction, 1=write
req_addr  in  NREQ*AW  per-requester address, requester i at bits [i*AW +: AW]
req_wdata  in  NREQ*DW  per-requester write data, requester i at bits [i*DW +: DW]
gnt  out  NREQ  one-hot, 1-cycle pulse: command captured
done  out  NREQ  one-hot, 1-cycle pulse: transfer finished
rdata  out  DW  read data of the last completed read
err  out  1  valid with done; 1=timeout abort
busy  out  1  high when state != IDLE
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  AW  APB address
pwdata  out  DW  APB write data
pwrite  out  1  APB direction
prdata  in  DW  APB read data
pready  in  1  APB ready

Behaviour:
- Reset (rstn=0, asynchronous): all outputs are 0. State=IDLE. Round-robin pointer set so requester 0 has highest priority. Timeout counter=0. Reset mid-transfer drops psel/penable immediately; the aborted transfer gets no done.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE: req is sampled only in IDLE.
  - If any req bit is set, the winner is the first set bit searching upward (with wrap) from pointer+1.
  - At the edge: latch req_addr/req_wdata/req_wr of the winner into paddr/pwdata/pwrite. Set psel=1, gnt[winner]=1, pointer=winner. Go to SETUP.
- SETUP: psel=1, penable=0, gnt pulse visible this cycle only. The requester must drop req on seeing gnt; a req still high in the next IDLE is treated as a new command. Next state is ACCESS with penable=1.
- ACCESS: psel=1, penable=1.
  - pready=1: go to IDLE. psel/penable=0, done[owner]=1, err=0. If pwrite=0, rdata<=prdata; otherwise rdata holds its value.
  - pready=0: timeout counter increments. When it reaches TIMEOUT (TIMEOUT>0), go to IDLE with psel/penable=0, done[owner]=1, err=1, rdata unchanged.
  - The counter clears on leaving ACCESS.
- Latency: req seen in IDLE cycle T gives SETUP at T+1 and ACCESS at T+2. With zero-wait pready, done and IDLE are at T+3, and the next SETUP is at T+4. The minimum transfer period is 3 cycles.
- paddr, pwdata and pwrite stay stable from SETUP through the end of ACCESS, and hold their values in IDLE.
- Simultaneous requests: strict rotation. With all requesters requesting continuously, each is served once per NREQ grants.
- err is meaningful only in the done cycle and is cleared to 0 in the following cycle. done and gnt are never high for two consecutive cycles.
- Inputs for non-winning requesters are ignored.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - default AW=3, DW=5
  - TIMEOUT default
- One sub-module rr_arbiter (parameter NREQ):
  - inputs: req vector, pointer
  - outputs: one-hot grant and grant index, combinational
  - The pointer register lives in the parent.

Test Plan:
- Single write: req[0]=1, wr=1, addr=3'd5, wdata=5'd19, slave pready=1 in first ACCESS -> psel at T+1, penable at T+2 with paddr=5/pwdata=19/pwrite=1; done[0] at T+3 with err=0; gnt[0] at T+1.
- Single read with 2 wait states: req[1], wr=0, addr=3'd2, slave returns prdata=5'd27 after pready low 2 cycles -> ACCESS lasts 3 cycles, done[1] at T+5, rdata=27, err=0.
- Contention: req=2'b11 held with reissue after each done, pready=1 -> grant order 0,1,0,1; each done matches its gnt owner; no requester served twice in a row.
- Timeout: pready tied 0, TIMEOUT=15 -> ACCESS for 15 cycles, then done pulse with err=1, psel drops, rdata unchanged from prior value.
- Reset mid-ACCESS: assert rstn=0 during ACCESS -> psel/penable/gnt/done go 0 asynchronously; after release, req[1] and req[0] both high -> requester 0 granted first.
- Sticky req: requester keeps req high after gnt -> a second transfer with identical fields starts at the next IDLE; back-to-back period is 3 cycles.

Source files
------------

// File: rtl/apb_rr_scheduler_pkg.sv
// Shared types and defaults for the round-robin APB scheduler.
package apb_rr_scheduler_pkg;

   localparam int unsigned NREQ_DEF    = 2;
   localparam int unsigned AW_DEF      = 3;
   localparam int unsigned DW_DEF      = 5;
   localparam int unsigned TIMEOUT_DEF = 15;

   // Scheduler sequencing states; one APB transfer per SETUP/ACCESS pair.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // Width of a counter that must reach limit-1 (never narrower than 1 bit).
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/apb_rr_scheduler_if.sv
// Requester-side command lanes plus the shared APB bus, bundled for the scheduler.
interface apb_rr_scheduler_if
   import apb_rr_scheduler_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned DW   = DW_DEF
) ();

   // requester side
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_wr;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [DW-1:0]      rdata;
   logic               err;
   logic               busy;

   // APB side
   logic               psel;
   logic               penable;
   logic [AW-1:0]      paddr;
   logic [DW-1:0]      pwdata;
   logic               pwrite;
   logic [DW-1:0]      prdata;
   logic               pready;

   // The scheduler: consumes commands, masters the APB bus.
   modport master (
      input  req, req_wr, req_addr, req_wdata, prdata, pready,
      output gnt, done, rdata, err, busy,
             psel, penable, paddr, pwdata, pwrite
   );

   // The environment: requesters plus the APB slave.
   modport slave (
      output req, req_wr, req_addr, req_wdata, prdata, pready,
      input  gnt, done, rdata, err, busy,
             psel, penable, paddr, pwdata, pwrite
   );

endinterface

// File: rtl/apb_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request above the pointer, with wrap.
module apb_rr_scheduler_rr_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt_c,
   output logic [PW-1:0]   o_idx_c,
   output logic            o_any_c
);

   // Walk pointer+1 .. pointer+NREQ; the last candidate is the pointer itself.
   always_comb begin
      logic [PW-1:0] v_k;
      o_gnt_c = '0;
      o_idx_c = '0;
      o_any_c = 1'b0;
      v_k     = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         v_k = PW'((32'(i_ptr) + i) % NREQ);
         if (!o_any_c && i_req[v_k]) begin
            o_any_c      = 1'b1;
            o_gnt_c[v_k] = 1'b1;
            o_idx_c      = v_k;
         end
      end
   end

endmodule

// File: rtl/apb_rr_scheduler.sv
// Round-robin scheduler sharing one APB master among NREQ requesters.
module apb_rr_scheduler
   import apb_rr_scheduler_pkg::*;
#(
   parameter int unsigned NREQ    = NREQ_DEF,
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                rstn,
   apb_rr_scheduler_if.master  bus
);

   localparam int unsigned    PW       = $clog2(NREQ);
   localparam int unsigned    CW       = cnt_width(TIMEOUT);
   localparam bit             TMO_EN   = (TIMEOUT != 0);
   localparam logic [CW-1:0]  TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   state_t            r_state;
   logic [PW-1:0]     r_ptr;
   logic [CW-1:0]     r_cnt;
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   r_done;
   logic [DW-1:0]     r_rdata;
   logic              r_err;
   logic              r_busy;
   logic              r_psel;
   logic              r_penable;
   logic [AW-1:0]     r_paddr;
   logic [DW-1:0]     r_pwdata;
   logic              r_pwrite;

   logic [NREQ-1:0]   w_gnt;
   logic [PW-1:0]     w_idx;
   logic              w_any;
   logic [NREQ-1:0]   w_own;
   logic              w_tmo;
   logic [NREQ:0][AW-1:0] w_addr_acc;
   logic [NREQ:0][DW-1:0] w_wdata_acc;
   logic [NREQ:0]         w_wr_acc;

   apb_rr_scheduler_rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .o_gnt_c (w_gnt),
      .o_idx_c (w_idx),
      .o_any_c (w_any)
   );

   // One-hot mux of the winning requester's command fields.
   assign w_addr_acc[0]  = '0;
   assign w_wdata_acc[0] = '0;
   assign w_wr_acc[0]    = 1'b0;
   for (genvar g = 0; g < NREQ; g++) begin : g_sel
      assign w_addr_acc[g+1]  = w_addr_acc[g]  | (bus.req_addr[g*AW +: AW]  & {AW{w_gnt[g]}});
      assign w_wdata_acc[g+1] = w_wdata_acc[g] | (bus.req_wdata[g*DW +: DW] & {DW{w_gnt[g]}});
      assign w_wr_acc[g+1]    = w_wr_acc[g]    | (bus.req_wr[g] & w_gnt[g]);
   end

   // Owner of the transfer in flight is the last winner, held in the pointer.
   assign w_own = NREQ'(1) << r_ptr;
   assign w_tmo = TMO_EN && (r_cnt == TMO_LAST);

   // Scheduler FSM with all outputs registered; gnt/done/err are single-cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ST_IDLE;
         r_ptr     <= PW'(NREQ - 1);
         r_cnt     <= '0;
         r_gnt     <= '0;
         r_done    <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pwrite  <= 1'b0;
      end else begin
         r_gnt  <= '0;
         r_done <= '0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_paddr  <= w_addr_acc[NREQ];
                  r_pwdata <= w_wdata_acc[NREQ];
                  r_pwrite <= w_wr_acc[NREQ];
                  r_psel   <= 1'b1;
                  r_gnt    <= w_gnt;
                  r_ptr    <= w_idx;
                  r_busy   <= 1'b1;
                  r_state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (bus.pready) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_done    <= w_own;
                  r_busy    <= 1'b0;
                  r_cnt     <= '0;
                  if (!r_pwrite) begin
                     r_rdata <= bus.prdata;
                  end
                  r_state   <= ST_IDLE;
               end else if (w_tmo) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_done    <= w_own;
                  r_err     <= 1'b1;
                  r_busy    <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.done    = r_done;
   assign bus.rdata   = r_rdata;
   assign bus.err     = r_err;
   assign bus.busy    = r_busy;
   assign bus.psel    = r_psel;
   assign bus.penable = r_penable;
   assign bus.paddr   = r_paddr;
   assign bus.pwdata  = r_pwdata;
   assign bus.pwrite  = r_pwrite;

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// Directed bench for apb_rr_scheduler with a transfer scoreboard.
module tb_apb_rr_scheduler;

   localparam int unsigned NREQ    = 2;
   localparam int unsigned AW      = 3;
   localparam int unsigned DW      = 5;
   localparam int unsigned TIMEOUT = 15;
   localparam int unsigned AWT     = NREQ * AW;
   localparam int unsigned DWT     = NREQ * DW;

   typedef struct {
      int            idx;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic          err;
   } item_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   item_t         exp_q[$];
   int            n_cmp     = 0;
   int            n_bad     = 0;
   logic [DW-1:0] m_rdata   = '0;
   int            g_wait    = 0;
   logic          g_hang    = 1'b0;
   logic [DW-1:0] g_prdata  = '0;
   int            acc_cnt   = 0;
   logic          prev_gnt  = 1'b0;
   logic          prev_done = 1'b0;

   always #5 clk = ~clk;

   apb_rr_scheduler_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   apb_rr_scheduler #(
      .NREQ    (NREQ),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // APB slave: pready after g_wait low ACCESS cycles, never while hung.
   always @(negedge clk) begin
      if (bus.psel && bus.penable && !g_hang) begin
         bus.pready = (acc_cnt == g_wait);
         acc_cnt++;
      end else begin
         bus.pready = 1'b0;
         if (!(bus.psel && bus.penable)) acc_cnt = 0;
      end
      bus.prdata = g_prdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void push(input int idx, input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [DW-1:0] prd, input logic e);
      item_t it;
      it.idx   = idx;
      it.wr    = wr;
      it.addr  = a;
      it.wdata = d;
      it.err   = e;
      if (!wr && !e) m_rdata = prd;
      it.rdata = m_rdata;
      exp_q.push_back(it);
   endfunction

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req       = bus.req | (NREQ'(1) << i);
      bus.req_wr    = (bus.req_wr & ~(NREQ'(1) << i)) | (NREQ'(wr) << i);
      bus.req_addr  = (bus.req_addr & ~(AWT'(7) << (i*AW))) | (AWT'(a) << (i*AW));
      bus.req_wdata = (bus.req_wdata & ~(DWT'(31) << (i*DW))) | (DWT'(d) << (i*DW));
   endtask

   task automatic clr_req(input int i);
      bus.req = bus.req & ~(NREQ'(1) << i);
   endtask

   // Scoreboard: check gnt against the head command, pop and check on done.
   task automatic monitor();
      item_t it;
      if (rstn) begin
         if (bus.gnt != '0) begin
            check("gnt_b2b", 32'(prev_gnt), 0);
            if (exp_q.size() == 0) begin
               check("gnt_extra", 32'(bus.gnt), 0);
            end else begin
               it = exp_q[0];
               check("sb_gnt", 32'(bus.gnt), 32'(1) << it.idx);
               check("sb_paddr", 32'(bus.paddr), 32'(it.addr));
               check("sb_pwdata", 32'(bus.pwdata), 32'(it.wdata));
               check("sb_pwrite", 32'(bus.pwrite), 32'(it.wr));
            end
         end
         if (bus.done != '0) begin
            check("done_b2b", 32'(prev_done), 0);
            if (exp_q.size() == 0) begin
               check("done_extra", 32'(bus.done), 0);
            end else begin
               it = exp_q.pop_front();
               check("sb_done", 32'(bus.done), 32'(1) << it.idx);
               check("sb_err", 32'(bus.err), 32'(it.err));
               check("sb_rdata", 32'(bus.rdata), 32'(it.rdata));
            end
         end
         prev_gnt  = (bus.gnt != '0);
         prev_done = (bus.done != '0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (bus.done == '0 && cyc < 40);
      check("done_seen", 32'(bus.done != '0), 1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int w;
      bus.req       = '0;
      bus.req_wr    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // reset values
      #12;
      check("rst_psel",    32'(bus.psel), 0);
      check("rst_penable", 32'(bus.penable), 0);
      check("rst_gnt",     32'(bus.gnt), 0);
      check("rst_done",    32'(bus.done), 0);
      check("rst_busy",    32'(bus.busy), 0);
      check("rst_rdata",   32'(bus.rdata), 0);
      check("rst_err",     32'(bus.err), 0);
      check("rst_paddr",   32'(bus.paddr), 0);
      tick();
      rstn = 1'b1;

      // single zero-wait write from requester 0
      g_wait = 0;
      set_req(0, 1'b1, 3'd5, 5'd19);
      push(0, 1'b1, 3'd5, 5'd19, 5'd0, 1'b0);
      tick();
      check("wr_gnt",      32'(bus.gnt), 1);
      check("wr_setup_psel", 32'(bus.psel), 1);
      check("wr_setup_pen",  32'(bus.penable), 0);
      check("wr_busy",     32'(bus.busy), 1);
      clr_req(0);
      tick();
      check("wr_acc_pen",  32'(bus.penable), 1);
      check("wr_paddr",    32'(bus.paddr), 5);
      check("wr_pwdata",   32'(bus.pwdata), 19);
      check("wr_pwrite",   32'(bus.pwrite), 1);
      tick();
      check("wr_done",     32'(bus.done), 1);
      check("wr_err",      32'(bus.err), 0);
      check("wr_psel_off", 32'(bus.psel), 0);
      check("wr_idle",     32'(bus.busy), 0);

      // read with two wait states from requester 1
      g_wait   = 2;
      g_prdata = 5'd27;
      set_req(1, 1'b0, 3'd2, 5'd9);
      push(1, 1'b0, 3'd2, 5'd9, 5'd27, 1'b0);
      tick();
      check("rd_gnt", 32'(bus.gnt), 2);
      clr_req(1);
      wait_done(cyc);
      check("rd_latency", 32'(cyc), 4);
      check("rd_rdata",   32'(bus.rdata), 27);
      check("rd_err",     32'(bus.err), 0);

      // contention: both requesting, reissue after each done
      g_wait = 0;
      for (int k = 0; k < 4; k++) begin
         w = k % 2;
         if (w == 0) push(0, 1'b1, 3'd1, 5'd3, 5'd0, 1'b0);
         else        push(1, 1'b1, 3'd6, 5'd10, 5'd0, 1'b0);
      end
      set_req(0, 1'b1, 3'd1, 5'd3);
      set_req(1, 1'b1, 3'd6, 5'd10);
      for (int k = 0; k < 4; k++) begin
         w = k % 2;
         tick();
         check("cont_gnt", 32'(bus.gnt), 32'(1) << w);
         clr_req(w);
         tick();
         tick();
         check("cont_done", 32'(bus.done), 32'(1) << w);
         if (k < 3) begin
            if (w == 0) set_req(0, 1'b1, 3'd1, 5'd3);
            else        set_req(1, 1'b1, 3'd6, 5'd10);
         end else begin
            bus.req = '0;
         end
      end

      // sticky request: back-to-back identical transfers, 3-cycle period
      set_req(0, 1'b1, 3'd4, 5'd7);
      push(0, 1'b1, 3'd4, 5'd7, 5'd0, 1'b0);
      push(0, 1'b1, 3'd4, 5'd7, 5'd0, 1'b0);
      tick();
      check("sticky_gnt1", 32'(bus.gnt), 1);
      tick();
      tick();
      check("sticky_done1", 32'(bus.done), 1);
      tick();
      check("sticky_period", 32'(bus.gnt), 1);
      clr_req(0);
      tick();
      tick();
      check("sticky_done2", 32'(bus.done), 1);

      // timeout: slave never ready, read must not touch rdata
      g_hang = 1'b1;
      set_req(1, 1'b0, 3'd3, 5'd0);
      push(1, 1'b0, 3'd3, 5'd0, 5'd0, 1'b1);
      tick();
      check("tmo_gnt", 32'(bus.gnt), 2);
      clr_req(1);
      wait_done(cyc);
      check("tmo_latency", 32'(cyc), 16);
      check("tmo_err",     32'(bus.err), 1);
      check("tmo_psel",    32'(bus.psel), 0);
      check("tmo_rdata",   32'(bus.rdata), 27);
      tick();
      check("err_clear",   32'(bus.err), 0);
      check("done_clear",  32'(bus.done), 0);
      g_hang = 1'b0;

      // reset in the middle of ACCESS
      g_hang = 1'b1;
      set_req(0, 1'b1, 3'd7, 5'd30);
      push(0, 1'b1, 3'd7, 5'd30, 5'd0, 1'b0);
      tick();
      clr_req(0);
      tick();
      check("mid_in_access", 32'(bus.penable), 1);
      #2;
      rstn = 1'b0;
      #1;
      check("mid_psel",    32'(bus.psel), 0);
      check("mid_penable", 32'(bus.penable), 0);
      check("mid_gnt",     32'(bus.gnt), 0);
      check("mid_done",    32'(bus.done), 0);
      check("mid_busy",    32'(bus.busy), 0);
      exp_q.delete();
      m_rdata   = '0;
      prev_gnt  = 1'b0;
      prev_done = 1'b0;
      g_hang    = 1'b0;
      tick();
      rstn = 1'b1;
      set_req(1, 1'b1, 3'd2, 5'd11);
      set_req(0, 1'b1, 3'd6, 5'd21);
      push(0, 1'b1, 3'd6, 5'd21, 5'd0, 1'b0);
      push(1, 1'b1, 3'd2, 5'd11, 5'd0, 1'b0);
      tick();
      check("post_rst_prio", 32'(bus.gnt), 1);
      clr_req(0);
      tick();
      tick();
      check("post_rst_done0", 32'(bus.done), 1);
      tick();
      check("post_rst_gnt1", 32'(bus.gnt), 2);
      clr_req(1);
      tick();
      tick();
      check("post_rst_done1", 32'(bus.done), 2);
      tick();
      check("sb_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
